sha256_core: RTL

Single-block-at-a-time SHA-256 compression engine, one round per clock. It is the stage directly upstream of the board display/checker. It accepts a pre-padded 512-bit message block and produces the 256-bit digest on `hash_value`, plus a level `finished` flag that the display stage latches and compares against its expected digest. Multi-block messages are processed by chaining blocks through the internal digest register.

---
 rtl/sha256_core.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sha256_core.sv
// sha256_core
// Single-block SHA-256 compression engine, one round per clock.
// A pre-padded 512-bit block is accepted on a start pulse. Its digest appears on
// hash_value 65 edges later, and a level finished flag marks it as valid.
// Multi-block messages chain through the digest register when first_block is 0.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   start        request to compress block (accepted only in IDLE or DONE)
//   first_block  1: chain from the FIPS initial hash, 0: chain from hash_value
//   block        512-bit padded block, W0 = [511:480] ... W15 = [31:0]
//   busy         high while a block is being compressed
//   finished     high from the digest update until the next accepted start
//   hash_value   256-bit digest, H0 = [255:224] ... H7 = [31:0]

module sha256_core (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         first_block,
  input  logic [511:0] block,
  output logic         busy,
  output logic         finished,
  output logic [255:0] hash_value
);

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE, DONE} state_t;

  localparam logic [255:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  state_t state, next_state;

  logic [5:0]        round_idx;
  logic [15:0][31:0] w;
  logic [255:0]      h_chain;
  logic [31:0]       a, b, c, d, e, f, g, h;

  logic [255:0] chain_value;
  logic [31:0]  t1, t2, w_next;
  logic         accept;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] k_const(input logic [5:0] idx);
    case (idx)
      6'd0:  return 32'h428a2f98;  6'd1:  return 32'h71374491;
      6'd2:  return 32'hb5c0fbcf;  6'd3:  return 32'he9b5dba5;
      6'd4:  return 32'h3956c25b;  6'd5:  return 32'h59f111f1;
      6'd6:  return 32'h923f82a4;  6'd7:  return 32'hab1c5ed5;
      6'd8:  return 32'hd807aa98;  6'd9:  return 32'h12835b01;
      6'd10: return 32'h243185be;  6'd11: return 32'h550c7dc3;
      6'd12: return 32'h72be5d74;  6'd13: return 32'h80deb1fe;
      6'd14: return 32'h9bdc06a7;  6'd15: return 32'hc19bf174;
      6'd16: return 32'he49b69c1;  6'd17: return 32'hefbe4786;
      6'd18: return 32'h0fc19dc6;  6'd19: return 32'h240ca1cc;
      6'd20: return 32'h2de92c6f;  6'd21: return 32'h4a7484aa;
      6'd22: return 32'h5cb0a9dc;  6'd23: return 32'h76f988da;
      6'd24: return 32'h983e5152;  6'd25: return 32'ha831c66d;
      6'd26: return 32'hb00327c8;  6'd27: return 32'hbf597fc7;
      6'd28: return 32'hc6e00bf3;  6'd29: return 32'hd5a79147;
      6'd30: return 32'h06ca6351;  6'd31: return 32'h14292967;
      6'd32: return 32'h27b70a85;  6'd33: return 32'h2e1b2138;
      6'd34: return 32'h4d2c6dfc;  6'd35: return 32'h53380d13;
      6'd36: return 32'h650a7354;  6'd37: return 32'h766a0abb;
      6'd38: return 32'h81c2c92e;  6'd39: return 32'h92722c85;
      6'd40: return 32'ha2bfe8a1;  6'd41: return 32'ha81a664b;
      6'd42: return 32'hc24b8b70;  6'd43: return 32'hc76c51a3;
      6'd44: return 32'hd192e819;  6'd45: return 32'hd6990624;
      6'd46: return 32'hf40e3585;  6'd47: return 32'h106aa070;
      6'd48: return 32'h19a4c116;  6'd49: return 32'h1e376c08;
      6'd50: return 32'h2748774c;  6'd51: return 32'h34b0bcb5;
      6'd52: return 32'h391c0cb3;  6'd53: return 32'h4ed8aa4a;
      6'd54: return 32'h5b9cca4f;  6'd55: return 32'h682e6ff3;
      6'd56: return 32'h748f82ee;  6'd57: return 32'h78a5636f;
      6'd58: return 32'h84c87814;  6'd59: return 32'h8cc70208;
      6'd60: return 32'h90befffa;  6'd61: return 32'ha4506ceb;
      6'd62: return 32'hbef9a3f7;  6'd63: return 32'hc67178f2;
      default: return 32'h0;
    endcase
  endfunction

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and status outputs. busy is decoded from the state so that
  // reset clears it immediately without waiting for a clock edge.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = ROUND;
        end
      end
      ROUND: begin
        busy = 1'b1;
        if (round_idx == 6'd63) next_state = UPDATE;
      end
      UPDATE: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Round arithmetic. w[0] always holds W[t]; the message-schedule word that
  // enters at the top of the window is W[t+16].
  always_comb begin
    chain_value = first_block ? H_INIT : hash_value;
    t1     = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + k_const(round_idx) + w[0];
    t2     = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
    w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
  end

  // Datapath registers: window, working variables, chain value and digest
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      round_idx  <= 6'd0;
      w          <= '0;
      h_chain    <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
      finished   <= 1'b0;
      hash_value <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            for (int i = 0; i < 16; i++) w[i] <= block[511 - 32*i -: 32];
            h_chain   <= chain_value;
            {a, b, c, d, e, f, g, h} <= chain_value;
            round_idx <= 6'd0;
            finished  <= 1'b0;
          end
        end
        ROUND: begin
          a <= t1 + t2;
          b <= a;
          c <= b;
          d <= c;
          e <= d + t1;
          f <= e;
          g <= f;
          h <= g;
          w <= {w_next, w[15:1]};
          round_idx <= round_idx + 6'd1;
        end
        UPDATE: begin
          hash_value <= {h_chain[255:224] + a, h_chain[223:192] + b,
                         h_chain[191:160] + c, h_chain[159:128] + d,
                         h_chain[127:96]  + e, h_chain[95:64]   + f,
                         h_chain[63:32]   + g, h_chain[31:0]    + h};
          finished   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
